uart_tx_framer: RTL and testbench

Byte-wide UART transmitter that serialises bytes onto o_tx as 8-data-bit frames with optional parity and 1 or 2 stop bits. It is the transmit end of the board UART link and is driven by the CORDIC/echo datapath through a valid/ready handshake. Bit timing is derived from CLK_FREQ/BAUD_RATE on the single system clock (PLL output). The line idles high.

---
 rtl/uart_tx_framer.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Byte-wide UART transmitter. Each accepted byte is sent on o_tx as one frame:
//   start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop
//   bits (1). The line idles high. Bit timing is CLKS_PER_BIT = CLK_FREQ /
//   BAUD_RATE system clocks per bit.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_data   byte to transmit, sampled only on a handshake edge
//   i_valid  source has a byte
//   o_ready  block can accept a byte this cycle (registered, high only in IDLE)
//   o_tx     serial line, driven straight from a flop, idle high
//   o_busy   frame in progress, start bit through last stop bit
//
// Handshake: a byte transfers on a rising edge of i_clk where i_valid && o_ready
// are both high. The source may hold i_valid high for any number of cycles;
// i_data must be stable only on the transfer edge. o_ready is a flop output
// and never depends combinationally on i_valid. Once a byte is accepted,
// o_ready stays low until the frame's last stop bit has completed.
// -----------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 19_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  // Guarded so an illegal CLKS_PER_BIT still elaborates far enough to report.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_framer: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;       // baud counter, counts CNT_LOAD down to 0
  logic [2:0]       r_bit_idx;   // data bit being sent, 0..7
  logic             r_stop_idx;  // second stop bit in progress (STOP_BITS = 2)
  logic [7:0]       r_shift;     // latched byte; bit 0 is the bit on the line
  logic             r_par;       // parity bit computed once at accept time
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic             w_stop_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_par_nxt;
  logic             w_tx_nxt;
  logic             w_ready_nxt;
  logic             w_busy_nxt;

  logic             w_accept;
  logic             w_bit_done;

  // r_ready is only ever high in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept   = i_valid && r_ready;
  assign w_bit_done = (r_cnt == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = S_START;
          w_cnt_nxt      = CNT_LOAD;
          w_bit_idx_nxt  = '0;
          w_stop_idx_nxt = 1'b0;
          w_shift_nxt    = i_data;
          w_par_nxt      = (PARITY == 1) ? ~^i_data : ^i_data;
        end
      end

      S_START: begin
        if (w_bit_done) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt   = CNT_LOAD;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_done) begin
          if ((STOP_BITS == 2) && !r_stop_idx) begin
            w_stop_idx_nxt = 1'b1;
            w_cnt_nxt      = CNT_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so o_tx, o_ready and o_busy all
  // change on the same edge as the state and never glitch.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  assign o_tx    = r_tx;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Four framers share clock and reset:
//   sel 0 (u_a): 16 clk/bit, no parity,   1 stop bit
//   sel 1 (u_b): 16 clk/bit, even parity, 2 stop bits
//   sel 2 (u_c): 16 clk/bit, odd parity,  1 stop bit
//   sel 3 (u_d): defaults, 5208 clk/bit at a 10 ns clock
// Bytes are pushed to exp_q when handed to a framer and popped when the line
// waveform recorded at falling clock edges is decoded.
// rec_*[j] holds the value seen at the j-th falling edge after the handshake
// rising edge, i.e. the value present at rising edge k + j.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int CPB       = 16;
  localparam int CPB_DEF   = 5208;
  localparam int CLK_NS    = 10;
  localparam int REC_MAX   = 52200;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] data [4];
  logic [3:0] valid;
  logic [3:0] tx;
  logic [3:0] ready;
  logic [3:0] busy;

  logic a_tx, a_ready, a_busy;
  logic b_tx, b_ready, b_busy;
  logic c_tx, c_ready, c_busy;
  logic d_tx, d_ready, d_busy;

  assign tx    = {d_tx, c_tx, b_tx, a_tx};
  assign ready = {d_ready, c_ready, b_ready, a_ready};
  assign busy  = {d_busy, c_busy, b_busy, a_busy};

  uart_tx_framer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy));

  uart_tx_framer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy));

  uart_tx_framer #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(c_ready), .o_tx(c_tx), .o_busy(c_busy));

  uart_tx_framer u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[3]), .i_valid(valid[3]),
    .o_ready(d_ready), .o_tx(d_tx), .o_busy(d_busy));

  // ---------------------------------------------------------------------------
  // Scoreboard state and recording buffers
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  logic rec_tx    [0:REC_MAX-1];
  logic rec_ready [0:REC_MAX-1];
  logic rec_busy  [0:REC_MAX-1];

  initial begin
    #(CLK_NS * 150000);
    $display("FAIL watchdog: simulation did not finish, required finish before %0d cycles", 150000);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents b on framer sel, waits for the handshake edge, returns just after
  // it with i_valid dropped and i_data scrambled.
  task automatic send(input int sel, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    data[sel]  = b;
    valid[sel] = 1'b1;
    while (ready[sel] !== 1'b1 && n < 100000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100000) begin
      n_fail++;
      $display("FAIL send_timeout: sel %0d o_ready stayed low, required high", sel);
    end
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    valid[sel] = 1'b0;
    data[sel]  = 8'($urandom_range(0, 255));
  endtask

  task automatic capture(input int sel, input int n);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      rec_tx[j]    = tx[sel];
      rec_ready[j] = ready[sel];
      rec_busy[j]  = busy[sel];
    end
  endtask

  // Mid-bit sampling of the 8 data bits of a frame whose start bit begins at j.
  function automatic logic [7:0] decode(input int start, input int cpb);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = rec_tx[start + cpb * (i + 1) + cpb / 2];
    return d;
  endfunction

  function automatic int first_ready(input int from, input int n);
    for (int j = from; j <= n; j++) if (rec_ready[j] === 1'b1) return j;
    return -1;
  endfunction

  function automatic int first_idle(input int from, input int n);
    for (int j = from; j <= n; j++) if (rec_busy[j] === 1'b0) return j;
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    int errs;
    rst_n = 1'b0;
    valid = 4'hF;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== 4'hF || ready !== 4'hF || busy !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: tx=%b ready=%b busy=%b, required tx=1111 ready=1111 busy=0000",
                 tx, ready, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'h0;
    capture(0, 20);
    errs = 0;
    for (int j = 1; j <= 20; j++)
      if (rec_tx[j] !== 1'b1 || rec_busy[j] !== 1'b0 || rec_ready[j] !== 1'b1) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL reset_no_transfer: %0d cycles not idle after release, required 0", errs);
    end
  endtask

  task automatic test_basic_frame;
    logic [7:0] b, got, exp_b;
    logic       e;
    int         errs, fr;
    b = 8'h55;
    send(0, b);
    capture(0, 170);
    errs = 0;
    for (int j = 1; j <= 170; j++) begin
      if (j <= 16)       e = 1'b0;
      else if (j <= 144) e = b[(j - 17) / 16];
      else               e = 1'b1;
      if (rec_tx[j] !== e) errs++;
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL basic_waveform: %0d cycles wrong on o_tx for 0x55, required 0", errs);
    end
    fr = first_ready(1, 170);
    n_checks++;
    if (fr != 161) begin
      n_fail++;
      $display("FAIL basic_ready_return: o_ready back at cycle %0d, required 161", fr);
    end
    n_checks++;
    if (rec_busy[1] !== 1'b1 || first_idle(1, 170) != 161) begin
      n_fail++;
      $display("FAIL basic_busy: busy@1=%b idle at %0d, required 1 and 161",
               rec_busy[1], first_idle(1, 170));
    end
    got   = decode(1, CPB);
    exp_b = exp_q.pop_front();
    n_checks++;
    if (got !== exp_b) begin
      n_fail++;
      $display("FAIL basic_decode: got 0x%02h, required 0x%02h", got, exp_b);
    end
    // A few more patterns through the same framer.
    for (int t = 0; t < 3; t++) begin
      send(0, 8'($urandom_range(0, 255)));
      capture(0, 170);
      got   = decode(1, CPB);
      exp_b = exp_q.pop_front();
      n_checks++;
      if (got !== exp_b || first_ready(1, 170) != 161) begin
        n_fail++;
        $display("FAIL random_frame: got 0x%02h ready@%0d, required 0x%02h ready@161",
                 got, first_ready(1, 170), exp_b);
      end
    end
  endtask

  task automatic test_parity;
    logic [7:0] bytes_b [3];
    logic       par_b   [3];
    logic [7:0] bytes_c [2];
    logic       par_c   [2];
    logic [7:0] got, exp_b;
    int         errs;
    bytes_b[0] = 8'h55; par_b[0] = 1'b0;
    bytes_b[1] = 8'h07; par_b[1] = 1'b1;
    bytes_b[2] = 8'($urandom_range(0, 255));
    par_b[2]   = ^bytes_b[2];
    bytes_c[0] = 8'h55; par_c[0] = 1'b1;
    bytes_c[1] = 8'($urandom_range(0, 255));
    par_c[1]   = ~^bytes_c[1];

    // Even parity, two stop bits: 12-bit frame.
    for (int t = 0; t < 3; t++) begin
      send(1, bytes_b[t]);
      capture(1, 200);
      n_checks++;
      if (rec_tx[153] !== par_b[t]) begin
        n_fail++;
        $display("FAIL even_parity: byte 0x%02h parity %b, required %b",
                 bytes_b[t], rec_tx[153], par_b[t]);
      end
      errs = 0;
      for (int j = 161; j <= 192; j++) if (rec_tx[j] !== 1'b1) errs++;
      n_checks++;
      if (errs != 0 || first_ready(1, 200) != 193 || rec_busy[192] !== 1'b1) begin
        n_fail++;
        $display("FAIL two_stop_bits: %0d low stop cycles ready@%0d, required 0 and 193",
                 errs, first_ready(1, 200));
      end
      got   = decode(1, CPB);
      exp_b = exp_q.pop_front();
      n_checks++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL even_decode: got 0x%02h, required 0x%02h", got, exp_b);
      end
    end

    // Odd parity, one stop bit: 11-bit frame.
    for (int t = 0; t < 2; t++) begin
      send(2, bytes_c[t]);
      capture(2, 190);
      got   = decode(1, CPB);
      exp_b = exp_q.pop_front();
      n_checks++;
      if (rec_tx[153] !== par_c[t] || got !== exp_b || first_ready(1, 190) != 177) begin
        n_fail++;
        $display("FAIL odd_parity: par %b data 0x%02h ready@%0d, required %b 0x%02h 177",
                 rec_tx[153], got, first_ready(1, 190), par_c[t], exp_b);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got, exp_b;
    int         hs2_j;
    bit         sent2;
    int         n;
    @(negedge clk);
    data[0]  = 8'hA3;
    valid[0] = 1'b1;
    n = 0;
    while (ready[0] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    exp_q.push_back(8'hA3);
    @(posedge clk);
    sent2 = 1'b0;
    hs2_j = -1;
    // i_valid stays high; i_data is scrambled every cycle except the one in
    // which the framer is ready again, where it carries the second byte.
    for (int j = 1; j <= 340; j++) begin
      @(negedge clk);
      rec_tx[j]    = tx[0];
      rec_ready[j] = ready[0];
      rec_busy[j]  = busy[0];
      if (!sent2 && ready[0] === 1'b1) begin
        data[0] = 8'h3C;
        exp_q.push_back(8'h3C);
        sent2 = 1'b1;
        hs2_j = j;
      end else begin
        if (sent2) valid[0] = 1'b0;
        data[0] = 8'($urandom_range(0, 255));
      end
    end
    valid[0] = 1'b0;
    n_checks++;
    if (hs2_j != 161) begin
      n_fail++;
      $display("FAIL b2b_accept: second byte accepted at cycle %0d, required 161", hs2_j);
    end
    n_checks++;
    if (rec_tx[160] !== 1'b1 || rec_tx[161] !== 1'b1 || rec_tx[162] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: tx@160..162=%b%b%b, required 110",
               rec_tx[160], rec_tx[161], rec_tx[162]);
    end
    got   = decode(1, CPB);
    exp_b = exp_q.pop_front();
    n_checks++;
    if (got !== exp_b) begin
      n_fail++;
      $display("FAIL b2b_first: got 0x%02h, required 0x%02h", got, exp_b);
    end
    got   = decode(162, CPB);
    exp_b = exp_q.pop_front();
    n_checks++;
    if (got !== exp_b || first_ready(162, 340) != 322) begin
      n_fail++;
      $display("FAIL b2b_second: got 0x%02h ready@%0d, required 0x%02h ready@322",
               got, first_ready(162, 340), exp_b);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] got, exp_b, dropped;
    send(0, 8'h00);
    for (int j = 1; j < 40; j++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: tx=%b busy=%b at cycle 40, required 0 and 1", tx[0], busy[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: tx=%b ready=%b busy=%b, required 1 1 0",
               tx[0], ready[0], busy[0]);
    end
    dropped = exp_q.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'hF0);
    capture(0, 170);
    got   = decode(1, CPB);
    exp_b = exp_q.pop_front();
    n_checks++;
    if (got !== exp_b || rec_tx[1] !== 1'b0 || first_ready(1, 170) != 161) begin
      n_fail++;
      $display("FAIL midreset_next: got 0x%02h start=%b ready@%0d, required 0x%02h 0 161 (abandoned 0x%02h)",
               got, rec_tx[1], first_ready(1, 170), exp_b, dropped);
    end
  endtask

  task automatic test_defaults;
    logic [7:0] got, exp_b;
    int         run0, run1, j;
    real        per0, per1, lo, hi;
    send(3, 8'h41);
    capture(3, 52100);
    j = 1;
    run0 = 0;
    while (j <= 52100 && rec_tx[j] === 1'b0) begin run0++; j++; end
    run1 = 0;
    while (j <= 52100 && rec_tx[j] === 1'b1) begin run1++; j++; end
    per0 = real'(run0 * CLK_NS);
    per1 = real'(run1 * CLK_NS);
    lo   = 52080.0 * 0.999;
    hi   = 52080.0 * 1.001;
    n_checks++;
    if (per0 < lo || per0 > hi || per1 < lo || per1 > hi) begin
      n_fail++;
      $display("FAIL default_bit_period: start %0.1f ns bit0 %0.1f ns, required 52080 ns +-0.1%%",
               per0, per1);
    end
    got   = decode(1, CPB_DEF);
    exp_b = exp_q.pop_front();
    n_checks++;
    if (got !== exp_b || first_ready(1, 52100) != 10 * CPB_DEF + 1) begin
      n_fail++;
      $display("FAIL default_decode: got 0x%02h ready@%0d, required 0x%02h ready@%0d",
               got, first_ready(1, 52100), exp_b, 10 * CPB_DEF + 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    valid    = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    test_reset;
    test_basic_frame;
    test_parity;
    test_back_to_back;
    test_reset_mid_frame;
    test_defaults;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
